// File: rtl/at5351_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : at5351_ctrl
// Description : Control core for the AT5351 measurement front end.
//               - Two-byte-command SPI slave (mode 1, MSB first) driving the
//                 analog selectors, filter enables and external chip selects,
//                 with a selector readback path and an ADC count readout.
//               - Dual-slope ADC up/down tick counter, latched once per
//                 clk_5ms period.
//               - Timebase outputs (clk_4mhz strobe, clk_5ms square wave).
//               - Comparator debounce with rising/falling edge pulses.
// Ports       : clk_12mhz, rst (sync, active-high)
//               spi_clk/spi_mosi/spi_cs in, spi_miso out  : host SPI link
//               adc_comp in, adc_countn out               : ADC comparator
//               clk_4mhz, clk_5ms, clk_not_5ms out        : timebase
//               comp1_cs, comp2_cs, relay_cs, relay_reset : device selects
//               input_sel, mu_sel, avk_sel, fil1_sel, fil2_sel, ref_avk
//               pos_comparator, neg_comparator, antibounce
//               rd_data_out                               : readback register
// Revision    : 1.0 - initial release
// ============================================================================
module at5351_ctrl #(
  parameter int CLK_DIV4 = 3,
  parameter int WIN_CYC  = 120000,
  parameter int DEB_LEN  = 4
) (
  input  logic       clk_12mhz,
  input  logic       rst,
  input  logic       spi_clk,
  input  logic       spi_mosi,
  input  logic       spi_cs,
  output logic       spi_miso,
  input  logic       adc_comp,
  output logic       adc_countn,
  output logic       clk_4mhz,
  output logic       clk_5ms,
  output logic       clk_not_5ms,
  output logic       comp1_cs,
  output logic       comp2_cs,
  output logic       relay_cs,
  output logic       relay_reset,
  output logic [3:0] input_sel,
  output logic [2:0] mu_sel,
  output logic [3:0] avk_sel,
  output logic       fil1_sel,
  output logic       fil2_sel,
  output logic       pos_comparator,
  output logic       neg_comparator,
  output logic       ref_avk,
  output logic       antibounce,
  output logic [7:0] rd_data_out
);

  localparam int c_DIV_W  = (CLK_DIV4 > 1) ? $clog2(CLK_DIV4) : 1;
  localparam int c_HALF   = WIN_CYC / 2;
  localparam int c_HALF_W = (c_HALF > 1) ? $clog2(c_HALF) : 1;
  localparam logic [c_DIV_W-1:0]  c_DIV_LAST  = c_DIV_W'(CLK_DIV4 - 1);
  localparam logic [c_HALF_W-1:0] c_HALF_LAST = c_HALF_W'(c_HALF - 1);

  // Synchronizer bit order: {spi_clk, spi_mosi, spi_cs, adc_comp}
  logic [3:0]  meta_q, meta_d, sync_q, sync_d;
  logic        sclk_prev_q, sclk_prev_d;

  // SPI slave state
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]  byte_cnt_q, byte_cnt_d;
  logic [6:0]  rx_sh_q, rx_sh_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic        miso_q, miso_d;
  logic [47:0] snap_q, snap_d;

  // Command-controlled outputs
  logic [3:0]  input_sel_q, input_sel_d;
  logic [2:0]  mu_sel_q, mu_sel_d;
  logic [3:0]  avk_sel_q, avk_sel_d;
  logic        fil1_q, fil1_d, fil2_q, fil2_d;
  logic        comp1_cs_q, comp1_cs_d, comp2_cs_q, comp2_cs_d;
  logic        relay_cs_q, relay_cs_d, relay_reset_q, relay_reset_d;
  logic [2:0]  rd_src_q, rd_src_d;
  logic [7:0]  rd_data_q, rd_data_d;

  // Timebase and ADC counters
  logic [c_DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic                clk4_q, clk4_d;
  logic [c_HALF_W-1:0] half_cnt_q, half_cnt_d;
  logic                clk5_q, clk5_d;
  logic [23:0]         cnt_p_q, cnt_p_d, cnt_m_q, cnt_m_d;
  logic [23:0]         lat_p_q, lat_p_d, lat_m_q, lat_m_d;
  logic                countn_q, countn_d;

  // Comparator conditioning
  logic [DEB_LEN-1:0]  hist_q, hist_d;
  logic                antib_q, antib_d, pos_q, pos_d, neg_q, neg_d;

  logic       w_sclk, w_mosi, w_csn, w_comp;
  logic       w_sclk_rise, w_sclk_fall, w_win_end;
  logic [7:0] w_byte, w_tx_byte;
  logic [3:0] w_grp, w_n;

  assign w_sclk      = sync_q[3];
  assign w_mosi      = sync_q[2];
  assign w_csn       = sync_q[1];
  assign w_comp      = sync_q[0];
  assign w_sclk_rise = w_sclk & ~sclk_prev_q;
  assign w_sclk_fall = ~w_sclk & sclk_prev_q;
  assign w_byte      = {rx_sh_q, w_mosi};
  assign w_grp       = w_byte[7:4];
  assign w_n         = w_byte[3:0];

  // Window ends on the cycle clk_5ms is about to rise.
  assign w_win_end   = (half_cnt_q == c_HALF_LAST) && !clk5_q;

  // Byte presented on miso for the byte about to start. Byte 0 of any frame
  // always returns zero, so a stale cmd_q from the previous frame is harmless.
  always_comb begin
    w_tx_byte = 8'h00;
    if (cmd_q == 8'h02) begin
      if (byte_cnt_q == 4'd1) w_tx_byte = rd_data_q;
    end else if (cmd_q == 8'h05) begin
      case (byte_cnt_q)
        4'd1:    w_tx_byte = snap_q[47:40];
        4'd2:    w_tx_byte = snap_q[39:32];
        4'd3:    w_tx_byte = snap_q[31:24];
        4'd4:    w_tx_byte = snap_q[23:16];
        4'd5:    w_tx_byte = snap_q[15:8];
        4'd6:    w_tx_byte = snap_q[7:0];
        default: w_tx_byte = 8'h00;
      endcase
    end
  end

  // Synchronizers, SPI slave and command decode
  always_comb begin
    meta_d        = {spi_clk, spi_mosi, spi_cs, adc_comp};
    sync_d        = meta_q;
    sclk_prev_d   = w_sclk;
    bit_cnt_d     = bit_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    rx_sh_d       = rx_sh_q;
    cmd_d         = cmd_q;
    tx_sh_d       = tx_sh_q;
    miso_d        = miso_q;
    snap_d        = snap_q;
    input_sel_d   = input_sel_q;
    mu_sel_d      = mu_sel_q;
    avk_sel_d     = avk_sel_q;
    fil1_d        = fil1_q;
    fil2_d        = fil2_q;
    comp1_cs_d    = comp1_cs_q;
    comp2_cs_d    = comp2_cs_q;
    relay_cs_d    = relay_cs_q;
    relay_reset_d = relay_reset_q;
    rd_src_d      = rd_src_q;

    if (w_csn) begin
      bit_cnt_d  = 3'd0;
      byte_cnt_d = 4'd0;
      rx_sh_d    = 7'd0;
      tx_sh_d    = 8'd0;
      miso_d     = 1'b0;
    end else begin
      if (w_sclk_fall) begin
        rx_sh_d   = w_byte[6:0];
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          if (byte_cnt_q != 4'hF) byte_cnt_d = byte_cnt_q + 4'd1;
          if (byte_cnt_q == 4'd0) begin
            cmd_d = w_byte;
            // Latched values only; a coincident window end lands next cycle.
            if (w_byte == 8'h05) snap_d = {lat_p_q, lat_m_q};
          end else if (byte_cnt_q == 4'd1) begin
            case (cmd_q)
              8'h01: begin
                case (w_grp)
                  4'h1: begin
                    if ((w_n >= 4'd1) && (w_n <= 4'd4)) input_sel_d = 4'b0001 << (w_n - 4'd1);
                    else if (w_n == 4'hF)               input_sel_d = 4'b0000;
                  end
                  4'h2: begin
                    if ((w_n >= 4'd1) && (w_n <= 4'd3))      mu_sel_d = 3'b001 << (w_n - 4'd1);
                    else if ((w_n == 4'h0) || (w_n == 4'hF)) mu_sel_d = 3'b000;
                  end
                  4'h3: begin
                    if ((w_n >= 4'd1) && (w_n <= 4'd4)) avk_sel_d = 4'b0001 << (w_n - 4'd1);
                    else if (w_n == 4'hF)               avk_sel_d = 4'b0000;
                  end
                  4'h4: begin
                    if (w_n == 4'h0)      fil1_d = 1'b0;
                    else if (w_n == 4'hF) fil1_d = 1'b1;
                  end
                  4'h5: begin
                    if (w_n == 4'h0)      fil2_d = 1'b0;
                    else if (w_n == 4'hF) fil2_d = 1'b1;
                  end
                  default: ;
                endcase
              end
              8'h02: begin
                if ((w_byte >= 8'd1) && (w_byte <= 8'd5)) rd_src_d = w_byte[2:0];
              end
              8'h03: begin
                case (w_byte)
                  8'h01: begin comp1_cs_d = 1'b0; comp2_cs_d = 1'b1; relay_cs_d = 1'b1; end
                  8'h02: begin comp1_cs_d = 1'b1; comp2_cs_d = 1'b0; relay_cs_d = 1'b1; end
                  8'h03: begin comp1_cs_d = 1'b1; comp2_cs_d = 1'b1; relay_cs_d = 1'b0; end
                  8'h04: relay_reset_d = 1'b1;
                  8'h0F: begin
                    comp1_cs_d    = 1'b1;
                    comp2_cs_d    = 1'b1;
                    relay_cs_d    = 1'b1;
                    relay_reset_d = 1'b0;
                  end
                  default: ;
                endcase
              end
              default: ;
            endcase
          end
        end
      end
      // Mode 1: drive the next bit on the rising edge; the first rising edge
      // of a byte loads that byte's reply.
      if (w_sclk_rise) begin
        if (bit_cnt_q == 3'd0) begin
          miso_d  = w_tx_byte[7];
          tx_sh_d = {w_tx_byte[6:0], 1'b0};
        end else begin
          miso_d  = tx_sh_q[7];
          tx_sh_d = {tx_sh_q[6:0], 1'b0};
        end
      end
    end

    case (rd_src_q)
      3'd1:    rd_data_d = {4'd0, input_sel_q};
      3'd2:    rd_data_d = {5'd0, mu_sel_q};
      3'd3:    rd_data_d = {4'd0, avk_sel_q};
      3'd4:    rd_data_d = {7'd0, fil1_q};
      3'd5:    rd_data_d = {7'd0, fil2_q};
      default: rd_data_d = 8'd0;
    endcase
  end

  // Timebase, ADC counting and comparator conditioning
  always_comb begin
    div_cnt_d  = (div_cnt_q == c_DIV_LAST) ? '0 : div_cnt_q + 1'b1;
    clk4_d     = (div_cnt_q == '0);
    half_cnt_d = (half_cnt_q == c_HALF_LAST) ? '0 : half_cnt_q + 1'b1;
    clk5_d     = (half_cnt_q == c_HALF_LAST) ? ~clk5_q : clk5_q;

    cnt_p_d  = cnt_p_q;
    cnt_m_d  = cnt_m_q;
    lat_p_d  = lat_p_q;
    lat_m_d  = lat_m_q;
    countn_d = ~w_win_end;
    if (w_win_end) begin
      lat_p_d = cnt_p_q;
      lat_m_d = cnt_m_q;
      cnt_p_d = 24'd0;
      cnt_m_d = 24'd0;
    end else if (clk4_q) begin
      if (w_comp && !(&cnt_p_q))      cnt_p_d = cnt_p_q + 24'd1;
      else if (!w_comp && !(&cnt_m_q)) cnt_m_d = cnt_m_q + 24'd1;
    end

    // antibounce moves only once the last DEB_LEN samples all agree.
    hist_d  = {hist_q[DEB_LEN-2:0], w_comp};
    antib_d = antib_q;
    if (&hist_q)       antib_d = 1'b1;
    else if (~|hist_q) antib_d = 1'b0;
    pos_d = antib_d & ~antib_q;
    neg_d = ~antib_d & antib_q;
  end

  always_ff @(posedge clk_12mhz) begin
    if (rst) begin
      meta_q        <= 4'b0010;
      sync_q        <= 4'b0010;
      sclk_prev_q   <= 1'b0;
      bit_cnt_q     <= 3'd0;
      byte_cnt_q    <= 4'd0;
      rx_sh_q       <= 7'd0;
      cmd_q         <= 8'd0;
      tx_sh_q       <= 8'd0;
      miso_q        <= 1'b0;
      snap_q        <= 48'd0;
      input_sel_q   <= 4'd0;
      mu_sel_q      <= 3'd0;
      avk_sel_q     <= 4'd0;
      fil1_q        <= 1'b0;
      fil2_q        <= 1'b0;
      comp1_cs_q    <= 1'b1;
      comp2_cs_q    <= 1'b1;
      relay_cs_q    <= 1'b1;
      relay_reset_q <= 1'b0;
      rd_src_q      <= 3'd0;
      rd_data_q     <= 8'd0;
      div_cnt_q     <= '0;
      clk4_q        <= 1'b0;
      half_cnt_q    <= '0;
      clk5_q        <= 1'b0;
      cnt_p_q       <= 24'd0;
      cnt_m_q       <= 24'd0;
      lat_p_q       <= 24'd0;
      lat_m_q       <= 24'd0;
      countn_q      <= 1'b1;
      hist_q        <= '0;
      antib_q       <= 1'b0;
      pos_q         <= 1'b0;
      neg_q         <= 1'b0;
    end else begin
      meta_q        <= meta_d;
      sync_q        <= sync_d;
      sclk_prev_q   <= sclk_prev_d;
      bit_cnt_q     <= bit_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      rx_sh_q       <= rx_sh_d;
      cmd_q         <= cmd_d;
      tx_sh_q       <= tx_sh_d;
      miso_q        <= miso_d;
      snap_q        <= snap_d;
      input_sel_q   <= input_sel_d;
      mu_sel_q      <= mu_sel_d;
      avk_sel_q     <= avk_sel_d;
      fil1_q        <= fil1_d;
      fil2_q        <= fil2_d;
      comp1_cs_q    <= comp1_cs_d;
      comp2_cs_q    <= comp2_cs_d;
      relay_cs_q    <= relay_cs_d;
      relay_reset_q <= relay_reset_d;
      rd_src_q      <= rd_src_d;
      rd_data_q     <= rd_data_d;
      div_cnt_q     <= div_cnt_d;
      clk4_q        <= clk4_d;
      half_cnt_q    <= half_cnt_d;
      clk5_q        <= clk5_d;
      cnt_p_q       <= cnt_p_d;
      cnt_m_q       <= cnt_m_d;
      lat_p_q       <= lat_p_d;
      lat_m_q       <= lat_m_d;
      countn_q      <= countn_d;
      hist_q        <= hist_d;
      antib_q       <= antib_d;
      pos_q         <= pos_d;
      neg_q         <= neg_d;
    end
  end

  assign spi_miso       = miso_q;
  assign adc_countn     = countn_q;
  assign clk_4mhz       = clk4_q;
  assign clk_5ms        = clk5_q;
  assign clk_not_5ms    = ~clk5_q;
  assign comp1_cs       = comp1_cs_q;
  assign comp2_cs       = comp2_cs_q;
  assign relay_cs       = relay_cs_q;
  assign relay_reset    = relay_reset_q;
  assign input_sel      = input_sel_q;
  assign mu_sel         = mu_sel_q;
  assign avk_sel        = avk_sel_q;
  assign fil1_sel       = fil1_q;
  assign fil2_sel       = fil2_q;
  assign pos_comparator = pos_q;
  assign neg_comparator = neg_q;
  assign ref_avk        = |avk_sel_q;
  assign antibounce     = antib_q;
  assign rd_data_out    = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_at5351_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_at5351_ctrl
// Description : Self-checking bench for at5351_ctrl with a reduced ADC window.
//               Random SPI commands are checked against a behavioural model of
//               the selector/device-select state; ADC counts, timebase and
//               comparator pulses are checked against arithmetic expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_at5351_ctrl;

  localparam int WIN  = 3000;
  localparam int HALF = 5;

  logic clk = 1'b0, rst = 1'b1;
  logic spi_clk = 1'b0, spi_mosi = 1'b0, spi_cs = 1'b1, adc_comp = 1'b0;
  logic spi_miso, adc_countn, clk_4mhz, clk_5ms, clk_not_5ms;
  logic comp1_cs, comp2_cs, relay_cs, relay_reset, fil1_sel, fil2_sel;
  logic pos_comparator, neg_comparator, ref_avk, antibounce;
  logic [3:0] input_sel, avk_sel;
  logic [2:0] mu_sel;
  logic [7:0] rd_data_out;

  int n_checks = 0, n_fail = 0;
  int pos_seen = 0, neg_seen = 0;
  logic [7:0] tx_buf [8];
  logic [7:0] rx_buf [8];

  // Reference model of the command-controlled state
  logic [3:0] m_in, m_avk;
  logic [2:0] m_mu;
  logic m_f1, m_f2, m_c1, m_c2, m_rl, m_rr;
  int   m_src;

  at5351_ctrl #(.CLK_DIV4(3), .WIN_CYC(WIN), .DEB_LEN(4)) dut (
    .clk_12mhz(clk), .rst(rst), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
    .spi_cs(spi_cs), .spi_miso(spi_miso), .adc_comp(adc_comp),
    .adc_countn(adc_countn), .clk_4mhz(clk_4mhz), .clk_5ms(clk_5ms),
    .clk_not_5ms(clk_not_5ms), .comp1_cs(comp1_cs), .comp2_cs(comp2_cs),
    .relay_cs(relay_cs), .relay_reset(relay_reset), .input_sel(input_sel),
    .mu_sel(mu_sel), .avk_sel(avk_sel), .fil1_sel(fil1_sel), .fil2_sel(fil2_sel),
    .pos_comparator(pos_comparator), .neg_comparator(neg_comparator),
    .ref_avk(ref_avk), .antibounce(antibounce), .rd_data_out(rd_data_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pos_comparator) pos_seen++;
    if (neg_comparator) neg_seen++;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [25:0] dut_vec();
    return {input_sel, mu_sel, avk_sel, fil1_sel, fil2_sel, comp1_cs, comp2_cs,
            relay_cs, relay_reset, ref_avk, rd_data_out};
  endfunction

  function automatic logic [7:0] m_rd();
    case (m_src)
      1: return {4'd0, m_in};
      2: return {5'd0, m_mu};
      3: return {4'd0, m_avk};
      4: return {7'd0, m_f1};
      5: return {7'd0, m_f2};
      default: return 8'd0;
    endcase
  endfunction

  function automatic logic [25:0] exp_vec();
    return {m_in, m_mu, m_avk, m_f1, m_f2, m_c1, m_c2, m_rl, m_rr, (m_avk != 4'd0), m_rd()};
  endfunction

  task automatic model_reset();
    m_in = 0; m_mu = 0; m_avk = 0; m_f1 = 0; m_f2 = 0;
    m_c1 = 1; m_c2 = 1; m_rl = 1; m_rr = 0; m_src = 0;
  endtask

  task automatic model_cmd(input logic [7:0] cmd, input logic [7:0] data);
    int g, n;
    g = int'(data[7:4]);
    n = int'(data[3:0]);
    if (cmd == 8'h01) begin
      if (g == 1 && n >= 1 && n <= 4) m_in = 4'(1 << (n - 1));
      if (g == 1 && n == 15)          m_in = 0;
      if (g == 2 && n >= 1 && n <= 3) m_mu = 3'(1 << (n - 1));
      if (g == 2 && (n == 0 || n == 15)) m_mu = 0;
      if (g == 3 && n >= 1 && n <= 4) m_avk = 4'(1 << (n - 1));
      if (g == 3 && n == 15)          m_avk = 0;
      if (g == 4 && (n == 0 || n == 15)) m_f1 = (n == 15);
      if (g == 5 && (n == 0 || n == 15)) m_f2 = (n == 15);
    end else if (cmd == 8'h02) begin
      if (data >= 1 && data <= 5) m_src = int'(data);
    end else if (cmd == 8'h03) begin
      case (data)
        8'h01: {m_c1, m_c2, m_rl} = 3'b011;
        8'h02: {m_c1, m_c2, m_rl} = 3'b101;
        8'h03: {m_c1, m_c2, m_rl} = 3'b110;
        8'h04: m_rr = 1;
        8'h0F: begin {m_c1, m_c2, m_rl} = 3'b111; m_rr = 0; end
        default: ;
      endcase
    end
  endtask

  // Clocks out nbits from tx_buf, capturing miso just before each falling edge.
  task automatic spi_frame(input int nbits);
    spi_cs = 1'b0;
    wait_cyc(8);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = tx_buf[i / 8][7 - (i % 8)];
      wait_cyc(2);
      spi_clk = 1'b1;
      wait_cyc(HALF);
      rx_buf[i / 8][7 - (i % 8)] = spi_miso;
      spi_clk = 1'b0;
      wait_cyc(HALF);
    end
    wait_cyc(4);
    spi_cs = 1'b1;
    wait_cyc(8);
  endtask

  task automatic send_cmd(input logic [7:0] cmd, input logic [7:0] data, input int nbytes);
    tx_buf[0] = cmd;
    tx_buf[1] = data;
    for (int i = 2; i < 8; i++) tx_buf[i] = 8'($urandom);
    spi_frame(8 * nbytes);
    model_cmd(cmd, data);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_cyc(4);
    model_reset();
    n_checks++;
    if (dut_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL reset_sel got %h want %h", dut_vec(), exp_vec());
    end
    n_checks++;
    if ({spi_miso, clk_4mhz, clk_5ms, clk_not_5ms, adc_countn, pos_comparator,
         neg_comparator, antibounce} !== 8'b0001_1000) begin
      n_fail++;
      $display("FAIL reset_misc got %b want 00011000", {spi_miso, clk_4mhz, clk_5ms,
               clk_not_5ms, adc_countn, pos_comparator, neg_comparator, antibounce});
    end
    rst = 1'b0;
    wait_cyc(2);
  endtask

  task automatic test_selectors();
    send_cmd(8'h01, 8'h13, 2);
    n_checks++;
    if (input_sel !== 4'b0100) begin n_fail++; $display("FAIL sel_13 got %b want 0100", input_sel); end
    send_cmd(8'h01, 8'h1F, 2);
    n_checks++;
    if (input_sel !== 4'b0000) begin n_fail++; $display("FAIL sel_1F got %b want 0000", input_sel); end
    repeat (16) begin
      send_cmd(8'h01, {4'($urandom_range(0, 6)), 4'($urandom_range(0, 15))},
               ($urandom_range(0, 3) == 0) ? 3 : 2);
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL sel_rand got %h want %h", dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_readback();
    send_cmd(8'h01, 8'h22, 2);
    send_cmd(8'h02, 8'h02, 2);
    n_checks++;
    if (rd_data_out !== 8'h02) begin n_fail++; $display("FAIL rb_plan got %h want 02", rd_data_out); end
    send_cmd(8'h02, 8'h02, 2);
    n_checks++;
    if (rx_buf[1] !== 8'h02) begin n_fail++; $display("FAIL rb_miso_plan got %h want 02", rx_buf[1]); end
    repeat (6) begin
      send_cmd(8'h01, {4'($urandom_range(1, 5)), 4'($urandom_range(0, 15))}, 2);
      send_cmd(8'h02, ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(1, 5)), 2);
      n_checks++;
      if (rd_data_out !== m_rd()) begin
        n_fail++; $display("FAIL rb_reg got %h want %h", rd_data_out, m_rd());
      end
      send_cmd(8'h02, 8'(m_src), 2);
      n_checks++;
      if (rx_buf[1] !== m_rd()) begin
        n_fail++; $display("FAIL rb_miso got %h want %h", rx_buf[1], m_rd());
      end
    end
  endtask

  task automatic test_devsel();
    logic [7:0] plan [4];
    logic [7:0] pick [6];
    plan = '{8'h01, 8'h03, 8'h04, 8'h0F};
    pick = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h0F, 8'h00};
    for (int i = 0; i < 4; i++) begin
      send_cmd(8'h03, plan[i], 2);
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL devsel_plan%0d got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    repeat (10) begin
      int k;
      logic [7:0] d, c;
      k = $urandom_range(0, 5);
      d = (k == 5) ? 8'($urandom) : pick[k];
      c = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(4, 255)) : 8'h03;
      if (c == 8'h05) c = 8'h00;
      send_cmd(c, d, 2);
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL devsel_rand cmd %h data %h got %h want %h", c, d, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_abort();
    repeat (3) begin
      tx_buf[0] = ($urandom_range(0, 1) == 0) ? 8'h01 : 8'h03;
      tx_buf[1] = ($urandom_range(0, 1) == 0) ? {4'($urandom_range(1, 5)), 4'hF} : 8'h03;
      spi_frame(13);
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL abort_nochange got %h want %h", dut_vec(), exp_vec());
      end
      send_cmd(8'h01, {4'($urandom_range(1, 3)), 4'($urandom_range(1, 3))}, 2);
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL abort_next got %h want %h", dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_timebase();
    int highs, bad, k;
    logic prev;
    highs = 0; bad = 0;
    for (int i = 0; i < 30; i++) begin
      if (clk_4mhz) highs++;
      if (clk_not_5ms !== ~clk_5ms) bad++;
      wait_cyc(1);
    end
    n_checks++;
    if (highs != 10) begin n_fail++; $display("FAIL clk4_duty got %0d want 10", highs); end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL clk_not_5ms got %0d bad want 0", bad); end
    prev = clk_5ms; k = 0;
    while (clk_5ms === prev && k < WIN) begin wait_cyc(1); k++; end
    prev = clk_5ms; k = 0;
    while (clk_5ms === prev && k < WIN) begin wait_cyc(1); k++; end
    n_checks++;
    if (k != WIN / 2) begin n_fail++; $display("FAIL clk5_half got %0d want %0d", k, WIN / 2); end
  endtask

  task automatic test_adc();
    int hi, k, exp_p, exp_m, got_p, got_m;
    logic prev;
    hi = 3 * $urandom_range(100, 900);
    exp_p = hi / 3;
    exp_m = (WIN - hi) / 3;
    adc_comp = 1'b0;
    prev = clk_5ms; k = 0;
    wait_cyc(1);
    while (!(clk_5ms === 1'b1 && prev === 1'b0) && k < 2 * WIN) begin
      prev = clk_5ms; wait_cyc(1); k++;
    end
    n_checks++;
    if (k >= 2 * WIN) begin n_fail++; $display("FAIL adc_align got timeout want rising clk_5ms"); end
    adc_comp = 1'b1;
    wait_cyc(hi);
    adc_comp = 1'b0;
    wait_cyc(WIN - hi - 5);
    k = 0;
    while (adc_countn !== 1'b0 && k < 20) begin wait_cyc(1); k++; end
    n_checks++;
    if (k >= 20) begin n_fail++; $display("FAIL adc_countn got no pulse want low pulse"); end
    wait_cyc(1);
    n_checks++;
    if (adc_countn !== 1'b1) begin n_fail++; $display("FAIL adc_countn_width got %b want 1", adc_countn); end
    for (int i = 0; i < 8; i++) tx_buf[i] = 8'h00;
    tx_buf[0] = 8'h05;
    spi_frame(64);
    got_p = int'({rx_buf[1], rx_buf[2], rx_buf[3]});
    got_m = int'({rx_buf[4], rx_buf[5], rx_buf[6]});
    n_checks++;
    if (got_p < exp_p - 2 || got_p > exp_p + 2) begin
      n_fail++; $display("FAIL adc_count_p got %0d want %0d+-2", got_p, exp_p);
    end
    n_checks++;
    if (got_m < exp_m - 2 || got_m > exp_m + 2) begin
      n_fail++; $display("FAIL adc_count_m got %0d want %0d+-2", got_m, exp_m);
    end
    n_checks++;
    if ({rx_buf[0], rx_buf[7]} !== 16'h0000) begin
      n_fail++; $display("FAIL adc_pad got %h %h want 00 00", rx_buf[0], rx_buf[7]);
    end
  endtask

  task automatic test_debounce();
    int p0, n0, exp_pos, exp_neg, len;
    logic lvl, settled;
    adc_comp = 1'b0;
    wait_cyc(12);
    p0 = pos_seen; n0 = neg_seen;
    adc_comp = 1'b1; wait_cyc(2); adc_comp = 1'b0;
    wait_cyc(12);
    n_checks++;
    if (antibounce !== 1'b0 || pos_seen != p0 || neg_seen != n0) begin
      n_fail++; $display("FAIL deb_glitch got ab=%b pulses=%0d want ab=0 pulses=0",
                         antibounce, (pos_seen - p0) + (neg_seen - n0));
    end
    // Random runs: a run of >=4 cycles at a new level yields exactly one edge.
    settled = 1'b0; lvl = 1'b0; exp_pos = 0; exp_neg = 0;
    p0 = pos_seen; n0 = neg_seen;
    for (int s = 0; s < 24; s++) begin
      lvl = ~lvl;
      len = (s == 23) ? 12 : $urandom_range(1, 7);
      adc_comp = lvl;
      wait_cyc(len);
      if (len >= 4 && lvl != settled) begin
        if (lvl) exp_pos++; else exp_neg++;
        settled = lvl;
      end
    end
    wait_cyc(8);
    n_checks++;
    if (pos_seen - p0 != exp_pos) begin
      n_fail++; $display("FAIL deb_pos got %0d want %0d", pos_seen - p0, exp_pos);
    end
    n_checks++;
    if (neg_seen - n0 != exp_neg) begin
      n_fail++; $display("FAIL deb_neg got %0d want %0d", neg_seen - n0, exp_neg);
    end
    n_checks++;
    if (antibounce !== settled) begin
      n_fail++; $display("FAIL deb_level got %b want %b", antibounce, settled);
    end
    adc_comp = 1'b0;
    wait_cyc(12);
  endtask

  task automatic test_reset_mid();
    send_cmd(8'h01, 8'h32, 2);
    send_cmd(8'h03, 8'h04, 2);
    spi_cs = 1'b0;
    wait_cyc(6);
    spi_clk = 1'b1; wait_cyc(HALF); spi_clk = 1'b0; wait_cyc(HALF);
    rst = 1'b1;
    wait_cyc(3);
    spi_cs = 1'b1;
    model_reset();
    n_checks++;
    if (dut_vec() !== exp_vec() || spi_miso !== 1'b0 || clk_5ms !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid got %h want %h", dut_vec(), exp_vec());
    end
    rst = 1'b0;
    wait_cyc(4);
    for (int i = 0; i < 8; i++) tx_buf[i] = 8'h00;
    tx_buf[0] = 8'h05;
    spi_frame(56);
    n_checks++;
    if ({rx_buf[1], rx_buf[2], rx_buf[3], rx_buf[4], rx_buf[5], rx_buf[6]} !== 48'd0) begin
      n_fail++; $display("FAIL reset_counts got %h%h%h %h%h%h want 0", rx_buf[1], rx_buf[2],
                         rx_buf[3], rx_buf[4], rx_buf[5], rx_buf[6]);
    end
    send_cmd(8'h01, 8'h14, 2);
    n_checks++;
    if (dut_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL reset_after got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  initial begin
    test_reset();
    test_selectors();
    test_readback();
    test_devsel();
    test_abort();
    test_timebase();
    test_adc();
    test_debounce();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/at5351_ctrl.md
# at5351_ctrl

Control FPGA core for the AT5351 measurement front end. It is a single-clock block on `clk_12mhz` and contains four functions:
- a 2-byte-command SPI slave that drives the analog selectors and the external SPI chip selects,
- a dual-slope ADC up/down tick counter with a readback path,
- timebase outputs,
- comparator conditioning.

## Interface
- CLK_DIV4, 3: `clk_12mhz` cycles per 4 MHz tick.
- WIN_CYC, 120000: ADC window length in cycles (10 ms); half-window is 60000.
- DEB_LEN, 4: debounce length in cycles.

Ports:
- clk_12mhz  in  1  system clock; everything is synchronous to it.
- rst  in  1  reset, synchronous, active-high.
- spi_clk  in  1  SPI clock from the host, idle low.
- spi_mosi  in  1  host data.
- spi_cs  in  1  frame select, active-low.
- spi_miso  out  1  reply data.
- adc_comp  in  1  ADC comparator input.
- adc_countn  out  1  1-cycle low pulse when new counts are latched.
- clk_4mhz  out  1  divided clock.
- clk_5ms  out  1  10 ms period square wave.
- clk_not_5ms  out  1  inverse of `clk_5ms`.
- comp1_cs, comp2_cs, relay_cs  out  1 each  external chip selects, active-low.
- relay_reset  out  1  relay driver reset.
- input_sel  out  4  one-hot selector.
- mu_sel  out  3  one-hot selector.
- avk_sel  out  4  one-hot selector.
- fil1_sel, fil2_sel  out  1 each  filter enables.
- pos_comparator, neg_comparator  out  1 each  edge pulses.
- ref_avk  out  1  high when any `avk_sel` bit is set.
- antibounce  out  1  debounced comparator.
- rd_data_out  out  8  readback register.

## Operation
SPI slave (mode 1, MSB first):
- `spi_clk`, `spi_mosi` and `spi_cs` pass through 2-FF synchronizers before use.
- `mosi` is sampled on the falling edge of `spi_clk`. `miso` shifts on the rising edge.
- `spi_cs` high clears the bit and byte counters, discards any partial byte, and forces `miso` to 0.
- Byte 0 of a frame is CMD. Byte 1 is DATA.
- CMD/DATA actions execute when the 8th falling edge of byte 1 completes. Bytes after byte 1 are ignored except under CMD 0x05.

Command 0x00 and 0x04: no operation.

Command 0x01 sets selectors. DATA[7:4] picks the group; n = DATA[3:0]:
- Group 1: n=1..4 sets `input_sel` = one-hot bit n-1. n=F clears it.
- Group 2: n=1..3 sets `mu_sel` = one-hot bit n-1. n=0 or F clears it.
- Group 3: n=1..4 sets `avk_sel` = one-hot bit n-1. n=F clears it.
- Group 4: n=0 sets `fil1_sel`=0. n=F sets `fil1_sel`=1.
- Group 5: n=0 sets `fil2_sel`=0. n=F sets `fil2_sel`=1.
- Any other group or n value: no change.

Command 0x02 (readback):
- DATA 1..5 selects the source for `rd_data_out`: `input_sel`, `mu_sel`, `avk_sel`, `fil1_sel`, `fil2_sel`, zero-extended.
- `rd_data_out` is then continuously updated from that source.
- During byte 1 of a 0x02 frame, `miso` returns the current `rd_data_out`.

Command 0x03 (device select):
- DATA 01: `comp1_cs`=0, others high.
- DATA 02: `comp2_cs`=0, others high.
- DATA 03: `relay_cs`=0, others high.
- DATA 04: `relay_reset`=1.
- DATA 0F: all chip selects =1 and `relay_reset`=0.
- Any other DATA: ignored.

Command 0x05 (read ADC):
- At completion of the CMD byte, latched `count_p` and `count_m` are snapshotted.
- Bytes 1..6 shift out `count_p`[23:0] then `count_m`[23:0], MSB first.
- Any byte after byte 6 reads 0.

Timebase and ADC:
- `clk_4mhz` is high for 1 of every 3 cycles.
- `clk_5ms` toggles every 60000 cycles.
- A window is one full `clk_5ms` period, starting at its rising edge.
- On each `clk_4mhz` tick, synchronized `adc_comp`=1 increments `cnt_p` and 0 increments `cnt_m`. Both are 24-bit and saturate at all-ones.
- At window end both counts are latched, the counters clear, and `adc_countn` pulses low.

Comparator conditioning:
- `antibounce` follows synchronized `adc_comp` only after DEB_LEN equal samples in a row.
- `pos_comparator` and `neg_comparator` are 1-cycle pulses on the rising and falling edges of `antibounce`.

## Timing
- Reset values: `miso`=0, all `*_cs`=1, `relay_reset`=0, all selectors=0, `rd_data_out`=0, `clk_4mhz`=0, `clk_5ms`=0, `clk_not_5ms`=1, `adc_countn`=1, counts=0, comparator outputs=0.
- Command outputs update ≤4 cycles after the 8th falling edge of `spi_clk` in byte 1.
- The SPI half-period must be ≥4 `clk_12mhz` cycles.
- `spi_cs` rising mid-frame leaves all outputs unchanged.
- If a window end coincides with a 0x05 snapshot, the snapshot takes the previously latched values.
- Reset mid-frame or mid-window clears all state.

## Test plan
- Frame 0x01/0x13 → `input_sel`=4'b0100. Then frame 0x01/0x1F → `input_sel`=0.
- Frames 0x01/0x22 then 0x02/0x02 → `rd_data_out`=8'h02. A following 0x02 frame returns 0x02 on `miso` in byte 1.
- 0x03/0x01 → `comp1_cs`=0. 0x03/0x03 → only `relay_cs`=0. 0x03/0x04 → `relay_reset`=1. 0x03/0x0F → all chip selects =1, `relay_reset`=0.
- `adc_comp` 6 ms high / 4 ms low, aligned to the window → latched counts 24000±2 and 16000±2, readable via a 7-byte 0x05 frame.
- `spi_cs` raised after 5 bits of byte 1 → no output change. The next full frame decodes correctly.
- A 2-cycle glitch on `adc_comp` → `antibounce` unchanged, no edge pulses.
